// File: rtl/tile_pkg.sv
// Shared types and helpers for the tile engine: op and state encodings,
// saturating narrow, and accumulator width.
package tile_pkg;

  typedef enum logic [2:0] {NOP, ADD, SUB, MUL, DOT, RELU, MAX, RSVD} op_e;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FLUSH, ST_DONE} state_e;

  // Wide enough to hold the sum of e full-width signed products
  function automatic int acc_w(input int dw, input int e);
    return 2 * dw + $clog2(e);
  endfunction

  // Clamp x into the signed range of a w-bit value; caller truncates
  function automatic logic signed [63:0] sat_to_w(input logic signed [63:0] x, input int w);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/tile_alu.sv
// Combinational per-element operation. Overflow handling of ADD/SUB/MUL
// is selected by the TILE_SAT_EN macro (saturate) vs. default (wrap).
module tile_alu
  import tile_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic signed [DATA_W-1:0] i_a,
  input  logic signed [DATA_W-1:0] i_b,
  input  op_e                      i_op,
  output logic signed [DATA_W-1:0] o_y
);

  logic signed [DATA_W:0]     w_sum;
  logic signed [DATA_W:0]     w_diff;
  logic signed [2*DATA_W-1:0] w_prod;

  assign w_sum  = (DATA_W+1)'(i_a) + (DATA_W+1)'(i_b);
  assign w_diff = (DATA_W+1)'(i_a) - (DATA_W+1)'(i_b);
  assign w_prod = (2*DATA_W)'(i_a) * (2*DATA_W)'(i_b);

  function automatic logic [DATA_W-1:0] fit(input logic signed [63:0] x);
`ifdef TILE_SAT_EN
    return DATA_W'(sat_to_w(x, DATA_W));
`else
    return DATA_W'(x);
`endif
  endfunction

  always_comb begin
    o_y = '0;
    case (i_op)
      ADD:     o_y = fit(64'(w_sum));
      SUB:     o_y = fit(64'(w_diff));
      MUL:     o_y = fit(64'(w_prod));
      RELU:    o_y = i_a[DATA_W-1] ? '0 : i_a;
      MAX:     o_y = (i_a > i_b) ? i_a : i_b;
      default: o_y = '0;
    endcase
  end

endmodule

// File: rtl/tile_engine.sv
// Tile engine: streams one TILE_N x TILE_N tile from SRAM A/B through the ALU
// (or the DOT accumulator) into SRAM C. Optional saturation: TILE_SAT_EN.
module tile_engine
  import tile_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 10,
  parameter int TILE_N     = 4,
  parameter int GRID       = 8,
  parameter int TILE_IDX_W = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [2:0]            op_code,
  input  logic [TILE_IDX_W-1:0] tile_i,
  input  logic [TILE_IDX_W-1:0] tile_j,
  input  logic [DATA_W-1:0]     sram_A_dout,
  input  logic [DATA_W-1:0]     sram_B_dout,
  output logic                  tp_sram_A_ce,
  output logic                  tp_sram_A_we,
  output logic [ADDR_W-1:0]     tp_sram_A_addr,
  output logic [DATA_W-1:0]     tp_sram_A_din,
  output logic                  tp_sram_B_ce,
  output logic                  tp_sram_B_we,
  output logic [ADDR_W-1:0]     tp_sram_B_addr,
  output logic [DATA_W-1:0]     tp_sram_B_din,
  output logic                  tp_sram_C_ce,
  output logic                  tp_sram_C_we,
  output logic [ADDR_W-1:0]     tp_sram_C_addr,
  output logic [DATA_W-1:0]     tp_sram_C_din,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int E      = TILE_N * TILE_N;
  localparam int CNT_W  = $clog2(E);
  localparam int ACC_W  = acc_w(DATA_W, E);
  localparam int STAGES = 2;

  state_e                    r_state;
  op_e                       r_op;
  logic [ADDR_W-1:0]         r_base;
  logic [CNT_W-1:0]          r_cnt;
  logic                      r_err;
  // [0] read issue, [1] SRAM data valid, [2] C write
  logic [STAGES:0]           r_vld_pipe;
  logic [ADDR_W-1:0]         r_addr1;
  logic                      r_last1;
  logic [ADDR_W-1:0]         r_c_addr;
  logic [DATA_W-1:0]         r_c_din;
  logic                      r_last2;
  logic                      r_dot_wb;
  logic signed [ACC_W-1:0]   r_acc;

  logic [ADDR_W-1:0]         w_base;
  logic [ADDR_W-1:0]         w_rd_addr;
  logic                      w_rd_last;
  logic                      w_legal;
  logic signed [DATA_W-1:0]  w_a;
  logic signed [DATA_W-1:0]  w_b;
  logic signed [DATA_W-1:0]  w_alu_y;
  logic signed [2*DATA_W-1:0] w_prod;
  logic [DATA_W-1:0]         w_acc_nar;

  assign w_base    = ADDR_W'((32'(tile_i) * GRID + 32'(tile_j)) * E);
  assign w_rd_addr = r_base + ADDR_W'(r_cnt);
  assign w_rd_last = (r_cnt == CNT_W'(E - 1));
  assign w_legal   = (op_code != 3'd0) && (op_code != 3'd7);
  assign w_a       = sram_A_dout;
  assign w_b       = sram_B_dout;
  assign w_prod    = (2*DATA_W)'(w_a) * (2*DATA_W)'(w_b);

`ifdef TILE_SAT_EN
  assign w_acc_nar = DATA_W'(sat_to_w(64'(r_acc), DATA_W));
`else
  assign w_acc_nar = DATA_W'(r_acc);
`endif

  tile_alu #(.DATA_W(DATA_W)) u_alu (
    .i_a  (w_a),
    .i_b  (w_b),
    .i_op (r_op),
    .o_y  (w_alu_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_op       <= NOP;
      r_base     <= '0;
      r_cnt      <= '0;
      r_err      <= 1'b0;
      r_vld_pipe <= '0;
      r_addr1    <= '0;
      r_last1    <= 1'b0;
      r_c_addr   <= '0;
      r_c_din    <= '0;
      r_last2    <= 1'b0;
      r_dot_wb   <= 1'b0;
      r_acc      <= '0;
    end else begin
      r_vld_pipe[1] <= r_vld_pipe[0];
      r_addr1       <= w_rd_addr;
      r_last1       <= r_vld_pipe[0] && w_rd_last;
      r_vld_pipe[2] <= 1'b0;
      r_last2       <= 1'b0;
      r_dot_wb      <= 1'b0;

      if (r_vld_pipe[1]) begin
        if (r_op == DOT) begin
          r_acc    <= r_acc + ACC_W'(w_prod);
          r_dot_wb <= r_last1;
        end else begin
          r_vld_pipe[2] <= 1'b1;
          r_c_addr      <= r_addr1;
          r_c_din       <= w_alu_y;
          r_last2       <= r_last1;
        end
      end
      // DOT writes once, a cycle after the final accumulate settles
      if (r_dot_wb) begin
        r_vld_pipe[2] <= 1'b1;
        r_c_addr      <= r_base;
        r_c_din       <= w_acc_nar;
        r_last2       <= 1'b1;
      end

      case (r_state)
        ST_IDLE: if (start) begin
          r_op   <= op_e'(op_code);
          r_base <= w_base;
          r_cnt  <= '0;
          r_acc  <= '0;
          if (w_legal) begin
            r_state       <= ST_RUN;
            r_vld_pipe[0] <= 1'b1;
          end else begin
            r_state <= ST_DONE;
            r_err   <= 1'b1;
          end
        end
        ST_RUN: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_rd_last) begin
            r_vld_pipe[0] <= 1'b0;
            r_state       <= ST_FLUSH;
          end
        end
        ST_FLUSH: if (r_vld_pipe[2] && r_last2) r_state <= ST_DONE;
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_err   <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign tp_sram_A_ce   = r_vld_pipe[0];
  assign tp_sram_A_we   = 1'b0;
  assign tp_sram_A_addr = w_rd_addr;
  assign tp_sram_A_din  = '0;
  assign tp_sram_B_ce   = r_vld_pipe[0] && (r_op != RELU);
  assign tp_sram_B_we   = 1'b0;
  assign tp_sram_B_addr = w_rd_addr;
  assign tp_sram_B_din  = '0;
  assign tp_sram_C_ce   = r_vld_pipe[2];
  assign tp_sram_C_we   = r_vld_pipe[2];
  assign tp_sram_C_addr = r_c_addr;
  assign tp_sram_C_din  = r_c_din;
  assign busy           = (r_state != ST_IDLE);
  assign done           = (r_state == ST_DONE);
  assign err            = r_err;

endmodule

// File: tb/tb_tile_engine.sv
// Directed bench for tile_engine with behavioural SRAMs and a write scoreboard.
module tb_tile_engine;
  localparam int DW = 8, AW = 10, TN = 4, G = 8, TW = 3, E = TN * TN;

  logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [2:0]    op_code = 3'd0;
  logic [TW-1:0] tile_i = '0, tile_j = '0;
  logic [DW-1:0] sram_A_dout, sram_B_dout;
  logic          tp_sram_A_ce, tp_sram_A_we, tp_sram_B_ce, tp_sram_B_we, tp_sram_C_ce, tp_sram_C_we;
  logic [AW-1:0] tp_sram_A_addr, tp_sram_B_addr, tp_sram_C_addr;
  logic [DW-1:0] tp_sram_A_din, tp_sram_B_din, tp_sram_C_din;
  logic          busy, done, err;

  tile_engine #(.DATA_W(DW), .ADDR_W(AW), .TILE_N(TN), .GRID(G), .TILE_IDX_W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_code(op_code),
    .tile_i(tile_i), .tile_j(tile_j),
    .sram_A_dout(sram_A_dout), .sram_B_dout(sram_B_dout),
    .tp_sram_A_ce(tp_sram_A_ce), .tp_sram_A_we(tp_sram_A_we),
    .tp_sram_A_addr(tp_sram_A_addr), .tp_sram_A_din(tp_sram_A_din),
    .tp_sram_B_ce(tp_sram_B_ce), .tp_sram_B_we(tp_sram_B_we),
    .tp_sram_B_addr(tp_sram_B_addr), .tp_sram_B_din(tp_sram_B_din),
    .tp_sram_C_ce(tp_sram_C_ce), .tp_sram_C_we(tp_sram_C_we),
    .tp_sram_C_addr(tp_sram_C_addr), .tp_sram_C_din(tp_sram_C_din),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] memA [1<<AW];
  logic [DW-1:0] memB [1<<AW];
  logic [DW-1:0] memC [1<<AW];

  // 1-cycle-latency single-port SRAMs
  always @(posedge clk) begin
    if (tp_sram_A_ce) sram_A_dout <= memA[tp_sram_A_addr];
    if (tp_sram_B_ce) sram_B_dout <= memB[tp_sram_B_addr];
    if (tp_sram_C_ce && tp_sram_C_we) memC[tp_sram_C_addr] <= tp_sram_C_din;
  end

  typedef struct {int addr; int data; int k;} wr_t;
  wr_t q[$];
  int compared = 0, mismatched = 0, spurious = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int fit(input int v);
`ifdef TILE_SAT_EN
    if (v > 127) v = 127;
    if (v < -128) v = -128;
`endif
    return v & 8'hFF;
  endfunction

  task automatic push(input int addr, input int data, input int k);
    wr_t w;
    w.addr = addr; w.data = data; w.k = k;
    q.push_back(w);
  endtask

  task automatic fill(input int base, input int a, input int b);
    for (int e = 0; e < E; e++) begin
      memA[base+e] = DW'(a);
      memB[base+e] = DW'(b);
    end
  endtask

  // k counts cycles after the start-sampling edge: k=1 is the cycle T0+1
  task automatic run_op(input logic [2:0] op, input int ti, input int tj, input int exp_done,
                        input bit exp_err, input bit no_bce, input int poke_k, input int rst_k);
    int k;
    bit fin;
    wr_t w;
    @(negedge clk);
    chk("done_low_before_start", done, 0);
    start = 1'b1; op_code = op; tile_i = TW'(ti); tile_j = TW'(tj);
    k = 0; fin = 1'b0;
    while (!fin) begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        start = 1'b0;
        chk("busy_at_T0+1", busy, 1);
      end
      if (poke_k > 0 && k == poke_k) begin start = 1'b1; op_code = 3'd7; end
      if (poke_k > 0 && k == poke_k + 1) start = 1'b0;
      if (no_bce) chk("relu_B_ce", tp_sram_B_ce, 0);
      if (tp_sram_C_ce && tp_sram_C_we) begin
        if (q.size() == 0) spurious++;
        else begin
          w = q.pop_front();
          chk("C_addr", tp_sram_C_addr, w.addr);
          chk("C_din", tp_sram_C_din, w.data);
          chk("C_cycle", k, w.k);
        end
      end
      if (rst_k > 0 && k == rst_k) begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_A_ce", tp_sram_A_ce, 0);
        chk("rst_C_ce", tp_sram_C_ce, 0);
        chk("rst_C_we", tp_sram_C_we, 0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        fin = 1'b1;
      end else if (done) begin
        chk("done_cycle", k, exp_done);
        chk("err", err, exp_err);
        chk("busy_at_done", busy, 1);
        if (exp_err) begin
          chk("illegal_A_ce", tp_sram_A_ce, 0);
          chk("illegal_B_ce", tp_sram_B_ce, 0);
          chk("illegal_C_ce", tp_sram_C_ce, 0);
        end
        fin = 1'b1;
      end else if (k > 60) begin
        chk("timeout_done_cycle", k, exp_done);
        fin = 1'b1;
      end
    end
    chk("scoreboard_drained", q.size(), 0);
  endtask

  initial begin
    int base, v;
    for (int i = 0; i < (1<<AW); i++) begin
      memA[i] = '0; memB[i] = '0; memC[i] = 8'hAA;
    end
    #12;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_err", err, 0);
    chk("reset_A_ce", tp_sram_A_ce, 0);
    chk("reset_C_we", tp_sram_C_we, 0);
    chk("reset_C_addr", tp_sram_C_addr, 0);
    @(negedge clk); rst_n = 1'b1;

    // ADD tile (0,0)
    fill(0, 8'h01, 8'h02);
    for (int e = 0; e < E; e++) push(e, 8'h03, 3 + e);
    run_op(3'd1, 0, 0, E + 3, 1'b0, 1'b0, 0, 0);

    // SUB tile (1,2), base 160
    base = 160;
    fill(base, 8'h03, 8'h05);
    for (int e = 0; e < E; e++) push(base + e, 8'hFE, 3 + e);
    run_op(3'd2, 1, 2, E + 3, 1'b0, 1'b0, 0, 0);
    @(negedge clk);
    chk("untouched_C159", memC[159], 8'hAA);
    chk("untouched_C176", memC[176], 8'hAA);
    chk("written_C175", memC[175], 8'hFE);

    // ADD overflow, tile (0,1)
    fill(16, 8'h70, 8'h70);
    for (int e = 0; e < E; e++) push(16 + e, fit(8'sh70 + 8'sh70), 3 + e);
    run_op(3'd1, 0, 1, E + 3, 1'b0, 1'b0, 0, 0);

    // MUL overflow, tile (0,2)
    fill(32, 8'h10, 8'h10);
    for (int e = 0; e < E; e++) push(32 + e, fit(16 * 16), 3 + e);
    run_op(3'd3, 0, 2, E + 3, 1'b0, 1'b0, 0, 0);

    // MAX with signed operands, tile (0,3)
    for (int e = 0; e < E; e++) begin
      memA[48+e] = DW'(e - 8); memB[48+e] = 8'h03;
      push(48 + e, ((e - 8) > 3 ? (e - 8) : 3) & 8'hFF, 3 + e);
    end
    run_op(3'd6, 0, 3, E + 3, 1'b0, 1'b0, 0, 0);

    // DOT tile (0,0): single write at base
    fill(0, 8'h01, 8'h01);
    push(0, fit(E), E + 3);
    run_op(3'd4, 0, 0, E + 4, 1'b0, 1'b0, 0, 0);
    @(negedge clk);
    chk("dot_C0", memC[0], 8'h10);
    chk("dot_no_write_C1", memC[1], 8'h03);
    chk("dot_no_write_C15", memC[15], 8'h03);

    // RELU tile (2,0), base 256
    for (int e = 0; e < E; e++) begin
      memA[256+e] = (e % 2) ? 8'h05 : 8'h85;
      push(256 + e, (e % 2) ? 8'h05 : 8'h00, 3 + e);
    end
    run_op(3'd5, 2, 0, E + 3, 1'b0, 1'b1, 0, 0);

    // Illegal op
    run_op(3'd7, 0, 0, 1, 1'b1, 1'b0, 0, 0);

    // ADD tile (3,3) with a stray start mid-run
    base = 432;
    fill(base, 8'h11, 8'h22);
    for (int e = 0; e < E; e++) push(base + e, 8'h33, 3 + e);
    run_op(3'd1, 3, 3, E + 3, 1'b0, 1'b0, 6, 0);

    // ADD tile (4,4) interrupted by reset during the third write, then rerun
    base = 576;
    fill(base, 8'h0A, 8'hF0);
    for (int e = 0; e < E; e++) push(base + e, 8'hFA, 3 + e);
    run_op(3'd1, 4, 4, E + 3, 1'b0, 1'b0, 0, 5);
    chk("pre_rst_write_C577", memC[577], 8'hFA);
    chk("no_write_after_rst_C578", memC[578], 8'hAA);
    for (int e = 0; e < E; e++) push(base + e, 8'hFA, 3 + e);
    run_op(3'd1, 4, 4, E + 3, 1'b0, 1'b0, 0, 0);
    @(negedge clk);
    v = memC[base + E - 1];
    chk("rerun_last_elem", v, 8'hFA);

    chk("spurious_C_writes", spurious, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
